aesl_axis_block_detector: RTL and testbench
===========================================

Name: aesl_axis_block_detector

Overview:
Producer side of the deadlock-monitor block-signal interface. Watches the tvalid/tready handshakes of N AXI-stream channels on one HLS instance. Asserts a per-channel block flag once a channel has stalled for STALL_THRESH consecutive cycles. Its axis_block_sigs output drives the axis_block_sigs input of the deadlock monitor tree, and it also keeps a sticky first-blocked-channel report for the simulation log.

Parameters:
N_CH, 3, number of monitored AXI-stream channels (1..32)
STALL_THRESH, 16, consecutive stall cycles before block asserts (>=1)
DIR_MASK, 3'b000, per-channel side: bit=1 consumer (stalls on empty), bit=0 producer (stalls on full)
CNT_W, $clog2(STALL_THRESH+1), stall counter width (derived, not overridden)

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
axis_tvalid  in  N_CH  per-channel TVALID
axis_tready  in  N_CH  per-channel TREADY
inst_idle  in  1  owning instance idle; forces all trackers to IDLE
clear_report  in  1  one-cycle pulse; clears sticky report
axis_block_sigs  out  N_CH  registered per-channel block flags
any_block  out  1  registered OR of axis_block_sigs
first_block_valid  out  1  sticky: a block has been captured
first_block_idx  out  5  index of the first channel that blocked

Behaviour:
- Stall condition for channel i:
  - producer (DIR_MASK[i]=0): tvalid & !tready
  - consumer (DIR_MASK[i]=1): tready & !tvalid
  - Handshake: tvalid & tready.
- Per-channel FSM: IDLE, WAIT, BLOCKED. Per-channel counter cnt[CNT_W].
  - IDLE: stall -> WAIT, cnt=1; if STALL_THRESH==1 -> BLOCKED directly.
  - WAIT: stall with cnt==STALL_THRESH-1 -> BLOCKED. Stall otherwise -> cnt+1. Handshake or no stall -> IDLE, cnt=0.
  - BLOCKED: stall -> stay (cnt saturates at STALL_THRESH). Handshake or no stall -> IDLE, cnt=0.
  - inst_idle=1 overrides everything: all channels go to IDLE with cnt=0 at the next edge.
- Latency: with the stall condition sampled true at STALL_THRESH consecutive edges, axis_block_sigs[i] is 1 immediately after the STALL_THRESH-th edge. Deassertion happens one edge after the stall clears.
- axis_block_sigs[i] = (state==BLOCKED), registered. any_block is registered from the next-state values, so it is cycle-aligned with axis_block_sigs.
- Sticky report:
  - Capture when first_block_valid==0 and at least one channel transitions into BLOCKED this edge.
  - first_block_idx = lowest such index; set first_block_valid=1.
  - Held until clear_report or reset.
  - clear_report together with a new entry into BLOCKED: the capture wins (valid stays 1, new idx).
  - Channels already BLOCKED when clear_report fires do not recapture; only a fresh entry into BLOCKED does.
- Reset: all FSMs IDLE, cnt=0, axis_block_sigs=0, any_block=0, first_block_valid=0, first_block_idx=0. Reset mid-stall discards the partial count.
- Channels are independent; simultaneous blocks on several channels all assert in the same cycle.
- X on tvalid/tready is treated as no stall.

Decomposition:
- Package aesl_deadlock_pkg: state enum {IDLE, WAIT, BLOCKED}, the IDX_W=5 constant, and a function computing CNT_W.
- One sub-module, aesl_axis_chan_stall_tracker: single-channel FSM plus counter, with parameters STALL_THRESH and IS_CONSUMER, outputs blocked and enter_blocked. The top generates N_CH of them and adds the priority encoder and sticky report.

Test Plan (N_CH=3, STALL_THRESH=4, DIR_MASK=3'b001):
- Ch1 tvalid=1, tready=0 for 4 cycles -> axis_block_sigs=3'b010 after the 4th edge; first_block_valid=1, first_block_idx=1.
- Ch2 stalls 3 cycles, handshakes 1 cycle, then stalls 3 more -> axis_block_sigs[2] never asserts.
- Ch0 (consumer) tready=1, tvalid=0 for 6 cycles -> block[0]=1 from edge 4 to edge 6. Then tvalid=1 -> block[0]=0 after the next edge.
- Ch0 and ch2 both start stalling on the same cycle -> both block on the same edge; first_block_idx=0.
- Ch1 BLOCKED, then inst_idle=1 for 1 cycle -> all axis_block_sigs=0 next edge, cnt cleared. Stall resumes -> 4 more cycles are needed to block again.
- Sticky report: clear_report pulsed on the same edge ch2 enters BLOCKED -> first_block_valid=1, idx=2. Reset asserted mid-stall (cnt=2) -> all outputs 0, and the count restarts from 0 after reset.

Source files
------------

// File: rtl/aesl_deadlock_pkg.sv
// Shared types and constants for the deadlock-monitor block-signal producers.
// Both the tracker and the detector top import this package.
package aesl_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BLOCKED
  } stall_state_e;

  localparam int unsigned IDX_W = 5;

  // Counter must be able to hold STALL_THRESH itself (saturation value).
  function automatic int unsigned cnt_width(input int unsigned thresh);
    return $clog2(thresh + 1);
  endfunction

endpackage

// File: rtl/aesl_axis_chan_stall_tracker.sv
// Single-channel stall tracker: counts consecutive stall cycles on one AXI-stream
// channel and flags BLOCKED once the count reaches STALL_THRESH.
module aesl_axis_chan_stall_tracker
  import aesl_deadlock_pkg::*;
#(
  parameter int unsigned STALL_THRESH = 16,
  parameter bit          IS_CONSUMER  = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic tvalid,
  input  logic tready,
  input  logic inst_idle,
  output logic blocked,
  output logic blocked_next,
  output logic enter_blocked
);

  localparam int unsigned      CNT_W    = cnt_width(STALL_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STALL_THRESH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_THRESH - 1);

  stall_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;

  // Consumers stall waiting on data, producers stall waiting on space.
  assign stall = IS_CONSUMER ? (tready & ~tvalid) : (tvalid & ~tready);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // An unknown stall value falls through to the IDLE branch (treated as no stall).
  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    if (!inst_idle && stall) begin
      case (state_q)
        IDLE: begin
          if (STALL_THRESH == 1) begin
            state_d = BLOCKED;
            cnt_d   = CNT_MAX;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        WAIT: begin
          if (cnt_q == CNT_LAST) begin
            state_d = BLOCKED;
            cnt_d   = CNT_MAX;
          end else begin
            state_d = WAIT;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        BLOCKED: begin
          state_d = BLOCKED;
          cnt_d   = CNT_MAX;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    blocked       = (state_q == BLOCKED);
    blocked_next  = (state_d == BLOCKED);
    enter_blocked = blocked_next & ~blocked;
  end

endmodule

// File: rtl/aesl_axis_block_detector.sv
// Per-channel AXI-stream block detector feeding the deadlock monitor tree, with a
// sticky record of the first channel that blocked.
module aesl_axis_block_detector
  import aesl_deadlock_pkg::*;
#(
  parameter int unsigned    N_CH         = 3,
  parameter int unsigned    STALL_THRESH = 16,
  parameter logic [N_CH-1:0] DIR_MASK    = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_CH-1:0]  axis_tvalid,
  input  logic [N_CH-1:0]  axis_tready,
  input  logic             inst_idle,
  input  logic             clear_report,
  output logic [N_CH-1:0]  axis_block_sigs,
  output logic             any_block,
  output logic             first_block_valid,
  output logic [IDX_W-1:0] first_block_idx
);

  logic [N_CH-1:0]  blocked, blocked_next, enter_blocked;
  logic             any_block_q;
  logic             fb_valid_q, fb_valid_d;
  logic [IDX_W-1:0] fb_idx_q, fb_idx_d;
  logic             capture;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    aesl_axis_chan_stall_tracker #(
      .STALL_THRESH (STALL_THRESH),
      .IS_CONSUMER  (DIR_MASK[i])
    ) u_tracker (
      .clock         (clock),
      .reset         (reset),
      .tvalid        (axis_tvalid[i]),
      .tready        (axis_tready[i]),
      .inst_idle     (inst_idle),
      .blocked       (blocked[i]),
      .blocked_next  (blocked_next[i]),
      .enter_blocked (enter_blocked[i])
    );
  end

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_CH-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // A fresh entry into BLOCKED beats a simultaneous clear.
  always_comb begin
    capture    = (|enter_blocked) && (!fb_valid_q || clear_report);
    fb_valid_d = fb_valid_q;
    fb_idx_d   = fb_idx_q;
    if (capture) begin
      fb_valid_d = 1'b1;
      fb_idx_d   = lowest_idx(enter_blocked);
    end else if (clear_report) begin
      fb_valid_d = 1'b0;
      fb_idx_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      any_block_q <= 1'b0;
      fb_valid_q  <= 1'b0;
      fb_idx_q    <= '0;
    end else begin
      any_block_q <= |blocked_next;
      fb_valid_q  <= fb_valid_d;
      fb_idx_q    <= fb_idx_d;
    end
  end

  assign axis_block_sigs   = blocked;
  assign any_block         = any_block_q;
  assign first_block_valid = fb_valid_q;
  assign first_block_idx   = fb_idx_q;

endmodule

// File: tb/tb_aesl_axis_block_detector.sv
// Directed bench for aesl_axis_block_detector: a run-length model predicts each
// cycle's outputs into a scoreboard that is checked after the clock edge.
module tb_aesl_axis_block_detector;

  localparam int unsigned N_CH   = 3;
  localparam int unsigned THRESH = 4;
  localparam logic [2:0]  DIR    = 3'b001;

  typedef struct packed {
    logic [2:0] sigs;
    logic       any;
    logic       fv;
    logic [4:0] idx;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] axis_tvalid = '0;
  logic [2:0] axis_tready = '0;
  logic       inst_idle = 1'b0;
  logic       clear_report = 1'b0;
  logic [2:0] axis_block_sigs;
  logic       any_block;
  logic       first_block_valid;
  logic [4:0] first_block_idx;

  int tests = 0;
  int fails = 0;

  exp_t sb[$];

  // Reference model: consecutive-stall run lengths plus sticky report.
  int         run[3];
  logic [2:0] m_blk = '0;
  logic       m_fv = 1'b0;
  logic [4:0] m_idx = '0;

  aesl_axis_block_detector #(
    .N_CH         (N_CH),
    .STALL_THRESH (THRESH),
    .DIR_MASK     (DIR)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .axis_tvalid       (axis_tvalid),
    .axis_tready       (axis_tready),
    .inst_idle         (inst_idle),
    .clear_report      (clear_report),
    .axis_block_sigs   (axis_block_sigs),
    .any_block         (any_block),
    .first_block_valid (first_block_valid),
    .first_block_idx   (first_block_idx)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] vld, input logic [2:0] rdy, input logic idle,
                      input logic clr, input logic rst);
    exp_t       e;
    logic [2:0] blk_new;
    logic [2:0] enter;
    logic       st;
    axis_tvalid  = vld;
    axis_tready  = rdy;
    inst_idle    = idle;
    clear_report = clr;
    reset        = rst;
    for (int i = 0; i < 3; i++) begin
      st = DIR[i] ? (rdy[i] & ~vld[i]) : (vld[i] & ~rdy[i]);
      if (rst || idle || !st) run[i] = 0;
      else run[i] = run[i] + 1;
      blk_new[i] = (run[i] >= THRESH);
    end
    enter = blk_new & ~m_blk;
    if (rst) begin
      m_fv  = 1'b0;
      m_idx = '0;
    end else if ((|enter) && (!m_fv || clr)) begin
      m_fv  = 1'b1;
      m_idx = enter[0] ? 5'd0 : (enter[1] ? 5'd1 : 5'd2);
    end else if (clr) begin
      m_fv  = 1'b0;
      m_idx = '0;
    end
    m_blk  = blk_new;
    e.sigs = blk_new;
    e.any  = |blk_new;
    e.fv   = m_fv;
    e.idx  = m_idx;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk("block_sigs", 32'(axis_block_sigs), 32'(e.sigs));
    chk("any_block", 32'(any_block), 32'(e.any));
    chk("first_valid", 32'(first_block_valid), 32'(e.fv));
    chk("first_idx", 32'(first_block_idx), 32'(e.idx));
  endtask

  task automatic rep(input int n, input logic [2:0] vld, input logic [2:0] rdy);
    for (int k = 0; k < n; k++) step(vld, rdy, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) run[i] = 0;

    // Reset state
    step(3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
    step(3'b010, 3'b000, 1'b0, 1'b0, 1'b1);
    chk("reset_sigs", 32'(axis_block_sigs), 32'd0);

    // Ch1 producer stalls 4 cycles
    rep(3, 3'b010, 3'b000);
    chk("ch1_not_yet", 32'(axis_block_sigs), 32'd0);
    rep(1, 3'b010, 3'b000);
    chk("ch1_blocked", 32'(axis_block_sigs), 32'b010);
    chk("ch1_report_idx", 32'(first_block_idx), 32'd1);
    rep(1, 3'b010, 3'b010);
    chk("ch1_release", 32'(axis_block_sigs), 32'd0);
    step(3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
    chk("report_cleared", 32'(first_block_valid), 32'd0);

    // Ch2 stall interrupted by a handshake never blocks
    rep(3, 3'b100, 3'b000);
    rep(1, 3'b100, 3'b100);
    rep(3, 3'b100, 3'b000);
    chk("ch2_no_block", 32'(axis_block_sigs), 32'd0);
    rep(1, 3'b000, 3'b000);

    // Ch0 consumer starved 6 cycles, then data arrives
    rep(6, 3'b000, 3'b001);
    chk("ch0_blocked", 32'(axis_block_sigs), 32'b001);
    rep(1, 3'b001, 3'b001);
    chk("ch0_release", 32'(axis_block_sigs), 32'd0);

    // Ch0 and ch2 stall together
    step(3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
    rep(4, 3'b100, 3'b001);
    chk("dual_block", 32'(axis_block_sigs), 32'b101);
    chk("dual_idx", 32'(first_block_idx), 32'd0);
    rep(1, 3'b000, 3'b000);

    // Ch1 blocked, then inst_idle wipes progress
    rep(4, 3'b010, 3'b000);
    step(3'b010, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("idle_clears", 32'(axis_block_sigs), 32'd0);
    rep(3, 3'b010, 3'b000);
    chk("idle_recount", 32'(axis_block_sigs), 32'd0);
    rep(1, 3'b010, 3'b000);
    chk("idle_reblock", 32'(axis_block_sigs), 32'b010);

    // Clear while ch1 stays blocked: no recapture
    step(3'b010, 3'b000, 1'b0, 1'b1, 1'b0);
    chk("no_recapture", 32'(first_block_valid), 32'd0);
    rep(1, 3'b000, 3'b000);

    // Clear on the same edge ch2 enters BLOCKED: capture wins
    step(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    rep(3, 3'b100, 3'b000);
    step(3'b100, 3'b000, 1'b0, 1'b1, 1'b0);
    chk("clr_capture_v", 32'(first_block_valid), 32'd1);
    chk("clr_capture_idx", 32'(first_block_idx), 32'd2);
    rep(1, 3'b000, 3'b000);

    // Reset mid-stall discards the partial count
    rep(2, 3'b010, 3'b000);
    step(3'b010, 3'b000, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_valid", 32'(first_block_valid), 32'd0);
    rep(3, 3'b010, 3'b000);
    chk("rst_recount", 32'(axis_block_sigs), 32'd0);
    rep(1, 3'b010, 3'b000);
    chk("rst_reblock", 32'(axis_block_sigs), 32'b010);
    rep(2, 3'b000, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
